// File: rtl/vt512_load_ctrl.sv
// vt512_load_ctrl: Wishbone-slave load controller for the VT512 accelerator.
// The host programs a channel and word count, then pushes words through a
// data window; each word leaves as a valid/ready beat tagged with channel id
// and last flag.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i       Wishbone strobe / cycle / write enable
//   wbs_sel_i                  byte selects (ignored, writes are full-word)
//   wbs_dat_i, wbs_adr_i       write data, byte address (offset = adr[3:2])
//   wbs_ack_o, wbs_dat_o       registered 1-cycle ack, read data valid with ack
//   out_valid_o/ready_i        stream handshake
//   out_data_o/chan_o/last_o   beat payload
//   busy_o                     transfer in progress
//   done_o                     1-cycle pulse when the last beat handshakes
//
// Register map (offset): 0x0 CTRL (W) [CH_W-1:0]=chan [8]=start [9]=abort
// [10]=clr_err; 0x4 LEN (R/W); 0x8 DATA (W);
// 0xC STATUS (R) {busy, err, 6'b0, chan[7:0], remaining[15:0]}.
module vt512_load_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned LEN_W      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_chan_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LEN    = 2'd1;
  localparam logic [1:0] OFF_DATA   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [CH_W-1:0]   chan_q;
  logic              err_q;

  // Bus decode: one access in flight, the ack cycle itself is never a new request
  logic        hit, req, wr;
  logic [1:0]  off;
  logic        ctrl_wr, len_wr, data_wr;
  logic        out_free, hs;
  logic        data_accept, data_stall, data_drop, accept;
  logic        abort_cmd, start_cmd, clr_cmd, start_ok, start_bad, set_err;
  logic        last_hs;
  logic [7:0]  req_chan;
  logic        chan_ok;
  logic [31:0] rdata;

  assign hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & hit;
  assign off      = wbs_adr_i[3:2];
  assign wr       = req & wbs_we_i;
  assign ctrl_wr  = wr & (off == OFF_CTRL);
  assign len_wr   = wr & (off == OFF_LEN);
  assign data_wr  = wr & (off == OFF_DATA);

  // Out register can take a new beat when empty or draining this cycle
  assign hs          = out_valid_o & out_ready_i;
  assign out_free    = ~out_valid_o | out_ready_i;
  assign data_accept = data_wr & (state_q == ST_LOAD) & out_free;
  assign data_stall  = data_wr & (state_q == ST_LOAD) & ~out_free;
  assign data_drop   = data_wr & (state_q != ST_LOAD);
  assign accept      = req & ~data_stall;

  // Abort overrides a start issued in the same write
  assign abort_cmd = ctrl_wr & wbs_dat_i[9];
  assign start_cmd = ctrl_wr & wbs_dat_i[8] & ~wbs_dat_i[9];
  assign clr_cmd   = ctrl_wr & wbs_dat_i[10];

  // Whole chan byte is range-checked so stray upper bits are reported as errors
  assign req_chan  = wbs_dat_i[7:0];
  assign chan_ok   = (32'(req_chan) < NUM_CH);
  assign start_ok  = start_cmd & (state_q == ST_IDLE) & (len_q != '0) & chan_ok;
  assign start_bad = start_cmd & ~start_ok;
  assign set_err   = start_bad | data_drop;

  assign last_hs = hs & out_last_o & (state_q == ST_FLUSH) & ~abort_cmd;

  // Read mux
  always_comb begin
    rdata = '0;
    case (off)
      OFF_LEN:    rdata = 32'(len_q);
      OFF_STATUS: rdata = {busy_o, err_q, 6'b0, 8'(chan_q), 16'(rem_q)};
      default:    rdata = '0;
    endcase
  end

  // Byte selects and sub-word address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

  // Bus, register, out-register and FSM state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      busy_o      <= 1'b0;
      len_q       <= '0;
      rem_q       <= '0;
      chan_q      <= '0;
      err_q       <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_chan_o  <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept & ~wbs_we_i) ? rdata : '0;
      done_o    <= last_hs;

      if (len_wr) begin
        len_q <= LEN_W'(wbs_dat_i);
      end

      // Set wins over clear
      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_cmd) begin
        err_q <= 1'b0;
      end

      // Out register: reload in the handshake cycle keeps full throughput
      if (data_accept) begin
        out_valid_o <= 1'b1;
        out_data_o  <= DATA_WIDTH'(wbs_dat_i);
        out_chan_o  <= chan_q;
        out_last_o  <= (rem_q == LEN_W'(1));
      end else if (hs) begin
        out_valid_o <= 1'b0;
      end

      if (abort_cmd) begin
        state_q <= ST_IDLE;
        busy_o  <= 1'b0;
        rem_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              state_q <= ST_LOAD;
              busy_o  <= 1'b1;
              chan_q  <= CH_W'(req_chan);
              rem_q   <= len_q;
            end
          end
          ST_LOAD: begin
            if (data_accept) begin
              if (rem_q != '0) begin
                rem_q <= rem_q - LEN_W'(1);
              end
              if (rem_q == LEN_W'(1)) begin
                state_q <= ST_FLUSH;
              end
            end
          end
          ST_FLUSH: begin
            if (last_hs) begin
              state_q <= ST_IDLE;
              busy_o  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
